// File: rtl/apb_fifo_sequencer.sv
// APB-side sequencer for the AHB-to-APB bridge.
// Pops {write, addr, wdata} entries from the async FIFO read port and runs
// each one through APB SETUP/ACCESS, honouring Pready wait states.
// Optional build macro: APB_TIMEOUT_EN aborts an ACCESS phase that has
// waited TIMEOUT_CYC cycles and sets the sticky timeout_err flag.
//
// state  | meaning
// IDLE   | no transfer in flight, Psel low
// SETUP  | Psel high, Penable low, address/data presented
// ACCESS | Psel and Penable high, waiting for Pready
`timescale 1ns/1ps

module apb_fifo_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic                     sched_en,
  input  logic                     rempty,
  input  logic [ADDR_W+DATA_W:0]   rdata_temp,
  output logic                     rinc,
  output logic                     Psel,
  output logic                     Penable,
  output logic                     Pwrite,
  output logic [ADDR_W-1:0]        Paddr,
  output logic [DATA_W-1:0]        Pdata,
  input  logic                     Pready,
  input  logic [DATA_W-1:0]        Prdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [CNT_W-1:0]         xfer_cnt,
  output logic                     busy,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pdata_q, pdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]    xfer_cnt_q, xfer_cnt_d;
  logic                pop, done, abort;

`ifdef APB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  // Wait counter restarts in SETUP so every ACCESS phase gets a fresh budget.
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    abort         = 1'b0;
    if (state_q == SETUP) begin
      wait_cnt_d = '0;
    end else if (state_q == ACCESS && !Pready) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      abort      = (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1));
    end
    timeout_err_d = timeout_err_q | abort;
  end

  // Timeout bookkeeping registers.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state and pop decision; a completing ACCESS may chain straight into SETUP.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sched_en && !rempty) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (Pready) begin
          done = 1'b1;
          if (sched_en && !rempty) begin
            pop     = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the FIFO head on pop, capture read data and count completions.
  always_comb begin
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pdata_d     = pdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    xfer_cnt_d  = xfer_cnt_q;
    if (pop) begin
      pwrite_d = rdata_temp[ADDR_W+DATA_W];
      paddr_d  = rdata_temp[ADDR_W+DATA_W-1:DATA_W];
      pdata_d  = rdata_temp[DATA_W-1:0];
    end
    if (done) begin
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
      if (!pwrite_q) begin
        rsp_data_d  = Prdata;
        rsp_valid_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q     <= IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pdata_q     <= pdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  // The pop strobe is suppressed while reset is held so no entry is lost then.
  assign rinc      = pop & ~rrst;
  assign Psel      = (state_q != IDLE);
  assign Penable   = (state_q == ACCESS);
  assign busy      = (state_q != IDLE);
  assign Pwrite    = pwrite_q;
  assign Paddr     = paddr_q;
  assign Pdata     = pdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_apb_fifo_sequencer.sv
// Scoreboard bench for apb_fifo_sequencer: a FIFO model feeds entries, a
// simple APB slave inserts programmable wait states, and a monitor checks
// every completed APB transfer and read response against queued expectations.
`timescale 1ns/1ps

module tb_apb_fifo_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic              rclk = 1'b0;
  logic              rrst = 1'b1;
  logic              sched_en = 1'b0;
  logic              rempty;
  logic [AW+DW:0]    rdata_temp;
  logic              rinc;
  logic              Psel, Penable, Pwrite;
  logic [AW-1:0]     Paddr;
  logic [DW-1:0]     Pdata;
  logic              Pready;
  logic [DW-1:0]     Prdata = '0;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [CW-1:0]     xfer_cnt;
  logic              busy;
  logic              timeout_err;

  int n_vec = 0;
  int n_err = 0;

  apb_fifo_sequencer #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYC(16)) dut (
    .rclk(rclk), .rrst(rrst), .sched_en(sched_en), .rempty(rempty),
    .rdata_temp(rdata_temp), .rinc(rinc), .Psel(Psel), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pdata(Pdata), .Pready(Pready),
    .Prdata(Prdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .xfer_cnt(xfer_cnt), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 rclk = ~rclk;

  // FIFO model: first-word-fall-through head, popped on rinc.
  logic [AW+DW:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rempty     = (wr_ptr == rd_ptr);
  assign rdata_temp = mem[rd_ptr[5:0]];

  always @(posedge rclk) begin
    if (rinc) rd_ptr <= rd_ptr + 1;
  end

  // APB slave model: wait_cfg wait states in each ACCESS phase.
  int wait_cfg = 0;
  int wcnt = 0;
  assign Pready = (wcnt >= wait_cfg);

  always @(posedge rclk or posedge rrst) begin
    if (rrst) wcnt <= 0;
    else if (Psel && Penable) wcnt <= Pready ? 0 : wcnt + 1;
  end

  logic [AW+DW:0] exp_xfer [$];
  logic [DW-1:0]  exp_rsp  [$];
  int rsp_pulses = 0;

  // Monitor: compares each APB completion and read response with the scoreboard.
  logic [AW+DW:0] hold;
  bit hold_valid = 1'b0;
  always @(negedge rclk) begin
    logic [AW+DW:0] e;
    logic [DW-1:0]  r;
    if (rrst) begin
      hold_valid = 1'b0;
    end else begin
      if (Penable) begin
        n_vec++;
        if (!Psel) begin
          n_err++;
          $display("FAIL penable_implies_psel: Psel=%0b required 1", Psel);
        end
      end
      if (hold_valid && Psel && Penable) begin
        n_vec++;
        if ({Pwrite, Paddr, Pdata} !== hold) begin
          n_err++;
          $display("FAIL wait_stable: got %0h required %0h", {Pwrite, Paddr, Pdata}, hold);
        end
      end
      hold_valid = Psel && Penable && !Pready;
      hold       = {Pwrite, Paddr, Pdata};
      if (Psel && Penable && Pready) begin
        n_vec++;
        if (exp_xfer.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_xfer: got %0h required none", {Pwrite, Paddr, Pdata});
        end else begin
          e = exp_xfer.pop_front();
          if ({Pwrite, Paddr, Pdata} !== e) begin
            n_err++;
            $display("FAIL apb_xfer: got %0h required %0h", {Pwrite, Paddr, Pdata}, e);
          end
        end
      end
      if (rsp_valid) begin
        rsp_pulses++;
        n_vec++;
        if (exp_rsp.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rsp: got %0h required none", rsp_data);
        end else begin
          r = exp_rsp.pop_front();
          if (rsp_data !== r) begin
            n_err++;
            $display("FAIL rsp_data: got %0h required %0h", rsp_data, r);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [AW+DW:0] e, input bit expect_it);
    mem[wr_ptr[5:0]] = e;
    wr_ptr++;
    if (expect_it) exp_xfer.push_back(e);
  endtask

  task automatic wait_cnt(input logic [CW-1:0] target, input int budget, output int used);
    used = 0;
    while (xfer_cnt !== target && used < budget) begin
      tick();
      used++;
    end
    if (xfer_cnt !== target) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_xfer_timeout: xfer_cnt=%0d required %0d", xfer_cnt, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int used;
    int rp0;
    int p0;

    // Reset state
    #1;
    check("rst_ctrl", {rinc, Psel, Penable, Pwrite, rsp_valid, busy, timeout_err}, 7'b0);
    check("rst_data", {Paddr, Pdata, rsp_data, xfer_cnt}, '0);
    @(negedge rclk);
    rrst = 1'b0;
    sched_en = 1'b1;
    tick();

    // Single write, cycle by cycle
    push({1'b1, 32'h0000_0004, 32'h1111_1111}, 1'b1);
    #1;
    check("wr_rinc_N", rinc, 1'b1);
    tick();
    check("wr_setup_N1", {Psel, Penable, rinc}, 3'b100);
    tick();
    check("wr_access_N2", {Psel, Penable, Pwrite, Paddr, Pdata}, {3'b111, 32'h4, 32'h1111_1111});
    tick();
    check("wr_done", {Psel, busy, rempty, xfer_cnt}, {3'b001, 16'd1});

    // Read with 3 wait states
    wait_cfg = 3;
    Prdata = 32'hDEAD_BEEF;
    exp_rsp.push_back(32'hDEAD_BEEF);
    p0 = rsp_pulses;
    push({1'b0, 32'h0000_0008, 32'h0}, 1'b1);
    wait_cnt(16'd2, 20, used);
    check("rd_latency", used, 6);
    tick();
    tick();
    check("rd_pulses", rsp_pulses - p0, 1);
    check("rd_rsp_data", rsp_data, 32'hDEAD_BEEF);

    // Back-to-back writes
    wait_cfg = 0;
    rp0 = rd_ptr;
    for (int i = 0; i < 15; i++)
      push({1'b1, 32'h100 + 32'(4 * i), 32'h1111_1111 + 32'(i)}, 1'b1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!Psel) bad++;
      if (Penable !== 1'(i % 2)) bad++;
    end
    check("b2b_psel_penable", bad, 0);
    tick();
    check("b2b_end_idle", Psel, 1'b0);
    check("b2b_pops", rd_ptr - rp0, 15);
    check("b2b_cnt", xfer_cnt, 16'd17);

    // sched_en gating
    sched_en = 1'b0;
    push({1'b1, 32'h200, 32'hA0A0_0001}, 1'b1);
    push({1'b1, 32'h204, 32'hA0A0_0002}, 1'b1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rinc || Psel) bad++;
    end
    check("gate_hold", bad, 0);
    sched_en = 1'b1;
    #1;
    check("gate_rinc_on", rinc, 1'b1);
    tick();
    tick();
    sched_en = 1'b0;
    #1;
    check("gate_access_no_pop", {Penable, rinc}, 2'b10);
    tick();
    tick();
    check("gate_one_done", {Psel, rempty, xfer_cnt}, {2'b00, 16'd18});
    check("gate_left", wr_ptr - rd_ptr, 1);
    sched_en = 1'b1;
    wait_cnt(16'd19, 10, used);
    tick();

    // Reset mid-ACCESS, then resume
    wait_cfg = 1000;
    push({1'b1, 32'h300, 32'hCAFE_0000}, 1'b0);
    tick();
    tick();
    tick();
    check("rst_in_access", {Psel, Penable, Pready}, 3'b110);
    #2;
    rrst = 1'b1;
    #1;
    check("rst_async_ctrl", {rinc, Psel, Penable, busy, Pwrite, rsp_valid}, 6'b0);
    check("rst_async_data", {Paddr, Pdata, rsp_data, xfer_cnt}, '0);
    @(negedge rclk);
    rrst = 1'b0;
    wait_cfg = 0;
    tick();
    Prdata = 32'h1234_5678;
    exp_rsp.push_back(32'h1234_5678);
    push({1'b0, 32'h400, 32'h0}, 1'b1);
    wait_cnt(16'd1, 10, used);
    tick();
    tick();
    check("post_rst_rsp", rsp_data, 32'h1234_5678);
    check("post_rst_err", timeout_err, 1'b0);
    check("sb_xfer_drained", exp_xfer.size(), 0);
    check("sb_rsp_drained", exp_rsp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
